// File: rtl/backlight_frame_scheduler.sv
// Backlight frame scheduler.
// Ramps the backlight PWM duty toward a brightness target one step per video frame,
// emits a frame-aligned sync strobe and RGB mask, counts frames, and freezes the
// ramp when vsync disappears for too long.
module backlight_frame_scheduler #(
    parameter int PWM_W   = 10,
    parameter int STEP    = 16,
    parameter int TIMEOUT = 2000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync_in,
    input  logic             enable,
    input  logic [3:0]       target_level,
    input  logic [2:0]       channel_sel,
    output logic [PWM_W-1:0] pwm_value,
    output logic             sync_pulse,
    output logic [2:0]       channel_mask,
    output logic [15:0]      frame_count,
    output logic             busy,
    output logic             no_video,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RAMP   = 2'd2,
        UNUSED = 2'd3
    } state_t;

    localparam int               GAP_W    = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [PWM_W:0]   STEP_EXT = (PWM_W + 1)'(STEP);

    logic             r_vsyncPrev;
    logic             r_armed;
    logic             r_syncPulse;
    logic [2:0]       r_channelMask;
    logic [15:0]      r_frameCount;
    logic [GAP_W-1:0] r_gapCount;
    logic [PWM_W-1:0] r_pwmValue;
    state_t           r_state;

    logic             w_frameEdge;
    logic             w_noVideo;
    logic             w_hold;
    logic [PWM_W-1:0] w_target;
    logic [PWM_W:0]   w_targetExt;
    logic [PWM_W:0]   w_up;
    logic [PWM_W:0]   w_down;
    logic [PWM_W-1:0] w_stepped;
    logic [PWM_W-1:0] w_nextPwm;
    state_t           w_nextState;

    // r_armed keeps a vsync level that is already high when reset releases from
    // being mistaken for a frame edge; a low level must be seen first.
    assign w_frameEdge = vsync_in & ~r_vsyncPrev & r_armed;
    assign w_noVideo   = (r_gapCount == GAP_MAX);
    assign w_hold      = w_noVideo & ~w_frameEdge;
    assign w_target    = {target_level, {(PWM_W - 4){1'b0}}};
    assign w_targetExt = {1'b0, w_target};
    assign w_up        = {1'b0, r_pwmValue} + STEP_EXT;
    assign w_down      = {1'b0, r_pwmValue} - STEP_EXT;

    assign pwm_value    = r_pwmValue;
    assign sync_pulse   = r_syncPulse;
    assign channel_mask = r_channelMask;
    assign frame_count  = r_frameCount;
    assign busy         = (r_state == RAMP);
    assign no_video     = w_noVideo;
    assign state        = r_state;

    // Vsync history, frame strobe, channel mask and frame counter; all follow edges regardless of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsyncPrev   <= 1'b0;
            r_armed       <= 1'b0;
            r_syncPulse   <= 1'b0;
            r_channelMask <= 3'b111;
            r_frameCount  <= 16'd0;
        end else begin
            r_vsyncPrev <= vsync_in;
            if (!vsync_in) begin
                r_armed <= 1'b1;
            end
            r_syncPulse <= w_frameEdge;
            if (w_frameEdge) begin
                r_channelMask <= channel_sel;
                r_frameCount  <= r_frameCount + 16'd1;
            end
        end
    end

    // Cycles since the last frame edge, saturating at the video-loss threshold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gapCount <= '0;
        end else if (w_frameEdge) begin
            r_gapCount <= '0;
        end else if (r_gapCount != GAP_MAX) begin
            r_gapCount <= r_gapCount + GAP_ONE;
        end
    end

    // One clamped step toward the target in PWM_W+1 bits so neither end can wrap
    always_comb begin
        w_stepped = r_pwmValue;
        if (w_target > r_pwmValue) begin
            w_stepped = (w_up >= w_targetExt) ? w_target : w_up[PWM_W-1:0];
        end else if (w_target < r_pwmValue) begin
            w_stepped = (w_down[PWM_W] || (w_down <= w_targetExt)) ? w_target : w_down[PWM_W-1:0];
        end
    end

    // FSM state and duty register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pwmValue <= '1;
        end else begin
            r_state    <= w_nextState;
            r_pwmValue <= w_nextPwm;
        end
    end

    // Next-state and next-duty; enable dropping beats a simultaneous frame edge
    always_comb begin
        w_nextState = r_state;
        w_nextPwm   = r_pwmValue;
        if (r_state == UNUSED) begin
            w_nextState = IDLE;
        end else if (!w_hold) begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        w_nextState = TRACK;
                    end
                end
                TRACK: begin
                    if (!enable) begin
                        w_nextState = IDLE;
                    end else if (w_frameEdge && (w_target != r_pwmValue)) begin
                        w_nextPwm   = w_stepped;
                        w_nextState = (w_stepped == w_target) ? TRACK : RAMP;
                    end
                end
                RAMP: begin
                    if (!enable) begin
                        w_nextState = IDLE;
                    end else if (w_frameEdge) begin
                        w_nextPwm   = w_stepped;
                        w_nextState = (w_stepped == w_target) ? TRACK : RAMP;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/backlight_frame_scheduler.md
BACKLIGHT_FRAME_SCHEDULER -- requirements
Module: backlight_frame_scheduler

Interface
REQ-001 Parameters SHALL be:
- PWM_W, 10, width of backlight duty word.
- STEP, 16, duty change per frame while ramping.
- TIMEOUT, 2000000, clk cycles without a vsync rising edge before video-loss is declared.
REQ-002 Ports SHALL be:
- clk  in  1  pixel clock from HDMI decoder; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- vsync_in  in  1  decoder vsync, active high, already in clk domain.
- enable  in  1  1 = scheduler active, 0 = hold.
- target_level  in  4  requested brightness (switch bits 7:4).
- channel_sel  in  3  requested RGB enables (bit0 R, bit1 G, bit2 B).
- pwm_value  out  PWM_W  duty word to PWM generator.
- sync_pulse  out  1  one-cycle frame strobe to PWM generator sync input.
- channel_mask  out  3  frame-aligned RGB enables for pixel pipeline.
- frame_count  out  16  frames seen since reset.
- busy  out  1  high while in RAMP.
- no_video  out  1  video-loss flag.
- state  out  2  FSM state code.
REQ-003 One clock domain only; reset SHALL be synchronous and active-high, named reset; clock named clk.

Function
REQ-004 Frame edge SHALL be detected as vsync_in=1 while registered previous vsync_in=0; all edge-driven updates SHALL take effect on the following clock edge (1-cycle latency).
REQ-005 On every frame edge, regardless of enable, sync_pulse SHALL be 1 for exactly one cycle; otherwise 0.
REQ-006 On every frame edge, frame_count SHALL increment by 1, wrapping 16'hFFFF -> 0.
REQ-007 On every frame edge, channel_mask SHALL load channel_sel; channel_sel changes between edges SHALL NOT affect channel_mask.
REQ-008 Target duty SHALL be {target_level, (PWM_W-4) zero bits}, sampled only at frame edges.
REQ-009 FSM states SHALL be IDLE=0, TRACK=1, RAMP=2; code 3 unused and SHALL recover to IDLE next cycle.
REQ-010 IDLE: pwm_value held; enable=1 -> TRACK next cycle.
REQ-011 TRACK: on frame edge with target != pwm_value -> apply one step and enter RAMP; target == pwm_value -> stay.
REQ-012 RAMP: on each frame edge, pwm_value SHALL move toward the newly sampled target by STEP, clamped so it never passes target; reaching target -> TRACK on same update.
REQ-013 Step arithmetic SHALL use PWM_W+1 bits; no wrap below 0 or above 2^PWM_W-1.
REQ-014 enable=0 in TRACK or RAMP SHALL go to IDLE next cycle with pwm_value frozen at its current value.
REQ-015 busy SHALL equal (state == RAMP).
REQ-016 A gap counter SHALL count cycles since the last frame edge, saturating at TIMEOUT; at TIMEOUT no_video SHALL be 1.
REQ-017 While no_video=1, pwm_value, state and ramp progress SHALL be frozen; the next frame edge SHALL clear no_video and clear the gap counter, and be processed normally.
REQ-018 Frame edge and enable falling in the same cycle: enable wins for state/pwm_value; REQ-005..007 still apply.

Reset
REQ-019 Reset SHALL set pwm_value = all ones, sync_pulse = 0, channel_mask = 3'b111, frame_count = 0, busy = 0, no_video = 0, state = IDLE, gap counter = 0, and vsync history = 0.
REQ-020 Reset mid-ramp SHALL abandon the ramp; the first frame edge after reset SHALL be detected only from a 0->1 vsync_in transition after reset deasserts.

Verification
REQ-021 reset, then enable=1, target_level=4'h8, 3 vsync pulses -> pwm_value 1023 -> 1007 -> 991 -> 975; busy=1; sync_pulse 3 single-cycle pulses; frame_count=3.
REQ-022 pwm_value=520, target_level=4'h8 (512), 1 frame edge -> pwm_value=512 (clamped, not 504), state TRACK, busy=0.
REQ-023 channel_sel changed 3'b111 -> 3'b001 mid-frame -> channel_mask stays 3'b111 until next edge, then becomes 3'b001 one cycle after the edge.
REQ-024 vsync_in held low for TIMEOUT cycles -> no_video=1, pwm_value frozen; next vsync rising edge -> no_video=0, one ramp step applied.
REQ-025 frame_count preloaded to 16'hFFFE by 2 edges -> 16'hFFFF, then 0; enable dropped mid-ramp at pwm_value=800 -> IDLE, pwm_value stays 800 across later edges.
